// File: rtl/mul_prof_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_prof_pkg
// Brief    : Shared types, widths and limits for the multiplier error profiler.
// Revision : 1.0 - initial release
// ============================================================================
package mul_prof_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Deepest multiplier latency the sampling pipeline is meant to cover.
    localparam int MAX_LATENCY = 16;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int ed_w(input int w);
        return 2 * w;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w;
    endfunction

    // One extra bit so a sweep in which every pair errs still fits.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_error_profiler_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_error_profiler_if
// Brief    : Operand/result bus between the profiler and a multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_error_profiler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   mul_in1;
    logic [WIDTH-1:0]   mul_in2;
    logic [2*WIDTH-3:0] mul_out;
    logic               mul_overflow;

    modport master (
        output mul_in1,
        output mul_in2,
        input  mul_out,
        input  mul_overflow
    );

    modport slave (
        input  mul_in1,
        input  mul_in2,
        output mul_out,
        output mul_overflow
    );
endinterface
`default_nettype wire

// File: rtl/mul_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : mul_err_accum
// Brief    : Error distance of one sample and the running error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module mul_err_accum
    import mul_prof_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_clr,
    input  wire logic                       i_en,
    input  wire logic [prod_w(WIDTH)-1:0]   i_exact,
    input  wire logic [prod_w(WIDTH)-1:0]   i_approx,
    output logic      [cnt_w(WIDTH)-1:0]    o_err_count,
    output logic      [ed_w(WIDTH)-1:0]     o_max_ed,
    output logic      [sum_w(WIDTH)-1:0]    o_sum_ed
);
    localparam int CW = cnt_w(WIDTH);
    localparam int EW = ed_w(WIDTH);
    localparam int SW = sum_w(WIDTH);

    logic [EW-1:0] w_ed;
    logic [CW-1:0] r_err_count;
    logic [EW-1:0] r_max_ed;
    logic [SW-1:0] r_sum_ed;

    assign w_ed = (i_exact >= i_approx) ? (i_exact - i_approx) : (i_approx - i_exact);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_err_count <= '0;
            r_max_ed    <= '0;
            r_sum_ed    <= '0;
        end else if (i_en && (w_ed != '0)) begin
            r_err_count <= r_err_count + CW'(1);
            r_sum_ed    <= r_sum_ed + SW'(w_ed);
            if (w_ed > r_max_ed) begin
                r_max_ed <= w_ed;
            end
        end
    end

    assign o_err_count = r_err_count;
    assign o_max_ed    = r_max_ed;
    assign o_sum_ed    = r_sum_ed;

endmodule
`default_nettype wire

// File: rtl/mul_error_profiler.sv
`default_nettype none
// ============================================================================
// Module   : mul_error_profiler
// Brief    : Sweeps all operand pairs through a multiplier, profiles its error.
// Revision : 1.0 - initial release
// ============================================================================
module mul_error_profiler
    import mul_prof_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 0
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start,
    input  wire logic                      abort,
    mul_error_profiler_if.master           mul,
    output logic                           busy,
    output logic                           done,
    output logic [cnt_w(WIDTH)-1:0]        err_count,
    output logic [ed_w(WIDTH)-1:0]         max_ed,
    output logic [sum_w(WIDTH)-1:0]        sum_ed
);
    localparam int PW = prod_w(WIDTH);
    // Pattern of the drain pipeline once only the final pair is left in it.
    localparam logic [MUL_LATENCY:0] c_LAST_ONLY = (MUL_LATENCY + 1)'(1) << MUL_LATENCY;

    state_t                      r_state;
    logic [PW-1:0]               r_pair;
    logic                        r_vld0;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_accept;
    logic                        w_flush;
    logic [PW-1:0]               w_pair_nxt;
    logic [PW-1:0]               w_approx;
    logic [MUL_LATENCY:0]        w_vld_stage;
    logic [MUL_LATENCY:0][PW-1:0] w_exact_stage;

    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_flush    = abort && ((r_state == SWEEP) || (r_state == DRAIN));
    assign w_pair_nxt = r_pair + PW'(1);

    // Outputs are registered decodes of the state, so busy/done trail it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pair  <= '0;
            r_vld0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= ((r_state == SWEEP) || (r_state == DRAIN)) && !abort;
            r_done <= (r_state == DONE);
            r_vld0 <= w_accept || ((r_state == SWEEP) && !abort);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SWEEP;
                        r_pair  <= '0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_pair <= w_pair_nxt;
                        if (&w_pair_nxt) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_vld_stage == c_LAST_ONLY) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mul.mul_in1 = r_pair[PW-1:WIDTH];
    assign mul.mul_in2 = r_pair[WIDTH-1:0];

    // Stage 0 is the pair currently on the bus; later stages follow the multiplier latency.
    assign w_vld_stage[0]   = r_vld0;
    assign w_exact_stage[0] = PW'(r_pair[PW-1:WIDTH]) * PW'(r_pair[WIDTH-1:0]);

    genvar g;
    generate
        for (g = 1; g <= MUL_LATENCY; g++) begin : g_dly
            logic          r_vld;
            logic [PW-1:0] r_exact;

            always_ff @(posedge clk) begin
                if (rst || w_flush) begin
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_vld_stage[g-1];
                end
            end

            always_ff @(posedge clk) begin
                r_exact <= w_exact_stage[g-1];
            end

            assign w_vld_stage[g]   = r_vld;
            assign w_exact_stage[g] = r_exact;
        end
    endgenerate

    assign w_approx = {1'b0, mul.mul_overflow, mul.mul_out};

    mul_err_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_en        (w_vld_stage[MUL_LATENCY] && !w_flush),
        .i_exact     (w_exact_stage[MUL_LATENCY]),
        .i_approx    (w_approx),
        .o_err_count (err_count),
        .o_max_ed    (max_ed),
        .o_sum_ed    (sum_ed)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_error_profiler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_error_profiler
// Brief    : Directed scoreboard bench: three profilers against behavioural stubs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_error_profiler;

    typedef struct {
        logic [63:0] ec;
        logic [63:0] mx;
        logic [63:0] sm;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  abort;
    logic [2:0]  busy;
    logic [2:0]  done;
    int          mode_v [3] = '{0, 0, 3};
    int          n_checks = 0;
    int          n_err = 0;
    exp_t        sb [$];

    always #5 clk = ~clk;

    mul_error_profiler_if #(.WIDTH(4)) bus0 ();
    mul_error_profiler_if #(.WIDTH(4)) bus1 ();
    mul_error_profiler_if #(.WIDTH(8)) bus2 ();

    logic [8:0]  ec0, ec1;
    logic [7:0]  mx0, mx1;
    logic [15:0] sm0, sm1;
    logic [16:0] ec2;
    logic [15:0] mx2;
    logic [31:0] sm2;

    mul_error_profiler #(.WIDTH(4), .MUL_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .mul(bus0),
        .busy(busy[0]), .done(done[0]), .err_count(ec0), .max_ed(mx0), .sum_ed(sm0));
    mul_error_profiler #(.WIDTH(4), .MUL_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .mul(bus1),
        .busy(busy[1]), .done(done[1]), .err_count(ec1), .max_ed(mx1), .sum_ed(sm1));
    mul_error_profiler #(.WIDTH(8), .MUL_LATENCY(0)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .mul(bus2),
        .busy(busy[2]), .done(done[2]), .err_count(ec2), .max_ed(mx2), .sum_ed(sm2));

    logic [63:0] v_ec [3], v_mx [3], v_sm [3], v_in1 [3], v_in2 [3];
    assign v_ec[0] = 64'(ec0);  assign v_mx[0] = 64'(mx0);  assign v_sm[0] = 64'(sm0);
    assign v_ec[1] = 64'(ec1);  assign v_mx[1] = 64'(mx1);  assign v_sm[1] = 64'(sm1);
    assign v_ec[2] = 64'(ec2);  assign v_mx[2] = 64'(mx2);  assign v_sm[2] = 64'(sm2);
    assign v_in1[0] = 64'(bus0.mul_in1); assign v_in2[0] = 64'(bus0.mul_in2);
    assign v_in1[1] = 64'(bus1.mul_in1); assign v_in2[1] = 64'(bus1.mul_in2);
    assign v_in1[2] = 64'(bus2.mul_in1); assign v_in2[2] = 64'(bus2.mul_in2);

    // Stub products: 0 = top product bit dropped, 1 = always zero, 2 = exact,
    // 3 = top bit and low three bits dropped.
    function automatic logic [63:0] stub_f(input int mode, input int w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        logic [63:0] top;
        p   = a * b;
        top = 64'd1 << (2 * w - 1);
        case (mode)
            0:       return p & ~top;
            1:       return 64'd0;
            2:       return p;
            default: return p & ~(top | 64'd7);
        endcase
    endfunction

    logic [63:0] p0, p1, p2, p1_d1, p1_d2;
    always_comb p0 = stub_f(mode_v[0], 4, 64'(bus0.mul_in1), 64'(bus0.mul_in2));
    always_comb p1 = stub_f(mode_v[1], 4, 64'(bus1.mul_in1), 64'(bus1.mul_in2));
    always_comb p2 = stub_f(mode_v[2], 8, 64'(bus2.mul_in1), 64'(bus2.mul_in2));
    always_ff @(posedge clk) begin
        p1_d1 <= p1;
        p1_d2 <= p1_d1;
    end
    assign bus0.mul_out = p0[5:0];   assign bus0.mul_overflow = p0[6];
    assign bus1.mul_out = p1_d2[5:0]; assign bus1.mul_overflow = p1_d2[6];
    assign bus2.mul_out = p2[13:0];  assign bus2.mul_overflow = p2[14];

    // Golden statistics over pairs 0..npairs-1; the bus only carries 2w-1 product bits.
    function automatic void model(input int mode, input int w, input int npairs,
                                  output logic [63:0] ec, output logic [63:0] mx,
                                  output logic [63:0] sm);
        logic [63:0] a, b, ex, ap, ed;
        ec = 0; mx = 0; sm = 0;
        for (int p = 0; p < npairs; p++) begin
            a  = 64'(p >> w);
            b  = 64'(p & ((1 << w) - 1));
            ex = a * b;
            ap = stub_f(mode, w, a, b) & ((64'd1 << (2 * w - 1)) - 64'd1);
            ed = (ex > ap) ? ex - ap : ap - ex;
            if (ed != 0) begin
                ec = ec + 1;
                sm = sm + ed;
                if (ed > mx) mx = ed;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int d, input exp_t e);
        check({tag, " err_count"}, v_ec[d], e.ec);
        check({tag, " max_ed"},    v_mx[d], e.mx);
        check({tag, " sum_ed"},    v_sm[d], e.sm);
    endtask

    // Returns just after the accept edge; the cycle then running is cycle 1.
    task automatic accept(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic run_full(input int d, input int mode, input int w, input int lat,
                            input string tag);
        exp_t e;
        int   cyc;
        mode_v[d] = mode;
        model(mode, w, 1 << (2 * w), e.ec, e.mx, e.sm);
        e.lat = (1 << (2 * w)) + 2 + lat;
        sb.push_back(e);
        accept(d);
        cyc = 1;
        forever begin
            @(negedge clk);
            if (done[d] === 1'b1 || cyc >= e.lat + 50) break;
            @(posedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check({tag, " done seen"}, 64'(done[d]), 64'd1);
        check({tag, " done cycle"}, 64'(cyc), 64'(e.lat));
        check({tag, " busy at done"}, 64'(busy[d]), 64'd0);
        check_stats(tag, d, e);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done[d]), 64'd0);
    endtask

    task automatic run_abort(input int d, input int mode, input int w, input int c,
                             input string tag);
        exp_t e;
        int   seen;
        mode_v[d] = mode;
        model(mode, w, c - 1, e.ec, e.mx, e.sm);
        e.lat = 0;
        sb.push_back(e);
        accept(d);
        repeat (c - 1) @(posedge clk);
        #1 abort[d] = 1'b1;
        @(posedge clk);
        #1 abort[d] = 1'b0;
        @(negedge clk);
        check({tag, " busy after abort"}, 64'(busy[d]), 64'd0);
        e = sb.pop_front();
        check_stats(tag, d, e);
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done[d] !== 1'b0) seen++;
        end
        check({tag, " no done"}, 64'(seen), 64'd0);
        check({tag, " err_count held"}, v_ec[d], e.ec);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = '0; abort = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset done", 64'(done[0]), 64'd0);
        check("reset mul_in1", v_in1[0], 64'd0);
        check("reset mul_in2", v_in2[0], 64'd0);
        check_stats("reset", 0, '{ec: 0, mx: 0, sm: 0, lat: 0});
        check("reset w8 err_count", v_ec[2], 64'd0);

        run_full(0, 0, 4, 0, "w4 drop7");
        run_full(0, 1, 4, 0, "w4 zero");
        check("hold mul_in1", v_in1[0], 64'd15);
        check("hold mul_in2", v_in2[0], 64'd15);
        run_abort(0, 0, 4, 100, "abort100");
        run_abort(0, 0, 4, 200, "abort200");
        run_full(1, 2, 4, 2, "w4 lat2");

        // Second start mid-sweep must not restart the pair counter; then reset.
        mode_v[0] = 1;
        model(1, 4, 51, e.ec, e.mx, e.sm);
        e.lat = 0;
        sb.push_back(e);
        accept(0);
        repeat (49) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy start ignored", 64'(busy[0]), 64'd1);
        check("pair a after start", v_in1[0], 64'd3);
        check("pair b after start", v_in2[0], 64'd3);
        e = sb.pop_front();
        check_stats("partial before rst", 0, e);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst busy", 64'(busy[0]), 64'd0);
        check("rst done", 64'(done[0]), 64'd0);
        check("rst mul_in1", v_in1[0], 64'd0);
        check("rst mul_in2", v_in2[0], 64'd0);
        check_stats("rst", 0, '{ec: 0, mx: 0, sm: 0, lat: 0});
        repeat (5) @(negedge clk);
        check("rst idle busy", 64'(busy[0]), 64'd0);
        check("rst idle pair", v_in2[0], 64'd0);

        run_full(2, 3, 8, 0, "w8 trunc");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
